// File: rtl/seq_compare_pkg.sv
// Shared constants and FSM encoding for the sequential compare unit.
package seq_compare_pkg;

    localparam int WIDTH      = 32;
    localparam int CHUNK      = 4;
    localparam int NUM_CHUNKS = WIDTH / CHUNK;
    localparam int INDEX_BITS = $clog2(NUM_CHUNKS);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/seq_compare_unit_chunk_compare.sv
// Combinational CHUNK-bit equality and unsigned less-than.
module chunk_compare #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             eq,
    output logic             ltU
);

    assign eq  = (a == b);
    assign ltU = (a < b);

endmodule

// File: rtl/seq_compare_unit.sv
// Multi-cycle MSB-first signed/unsigned comparator with start/ready handshake.
// Optional macro SEQ_COMPARE_EARLY_EXIT_EN: finish on the first differing chunk.
module seq_compare_unit #(
    parameter int WIDTH = seq_compare_pkg::WIDTH,
    parameter int CHUNK = seq_compare_pkg::CHUNK
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_start,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic             busy,
    output logic             data_resultRDY,
    output logic             isEqual,
    output logic             isNotEqual,
    output logic             isLessThan,
    output logic             isLessThanU
);
    import seq_compare_pkg::*;

    localparam int N_CHUNKS = WIDTH / CHUNK;
    localparam int IDX_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   op_a, op_b;
    logic [IDX_W-1:0]   idx;
    logic               decided;
    logic               ltu_r;
    logic [CHUNK-1:0]   chunk_a, chunk_b;
    logic               c_eq, c_ltu;
    logic               last_chunk;
    logic               sign_diff;

    assign chunk_a    = op_a[int'(idx)*CHUNK +: CHUNK];
    assign chunk_b    = op_b[int'(idx)*CHUNK +: CHUNK];
    assign last_chunk = (idx == '0);
    assign sign_diff  = op_a[WIDTH-1] ^ op_b[WIDTH-1];
    assign busy       = (state == RUN);

    chunk_compare #(.CHUNK(CHUNK)) u_chunk_compare (
        .a   (chunk_a),
        .b   (chunk_b),
        .eq  (c_eq),
        .ltU (c_ltu)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (ctrl_start) state_nxt = RUN;
            RUN: begin
`ifdef SEQ_COMPARE_EARLY_EXIT_EN
                if (last_chunk || (!decided && !c_eq)) state_nxt = DONE;
`else
                if (last_chunk) state_nxt = DONE;
`endif
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            op_a           <= '0;
            op_b           <= '0;
            idx            <= '0;
            decided        <= 1'b0;
            ltu_r          <= 1'b0;
            data_resultRDY <= 1'b0;
            isEqual        <= 1'b0;
            isNotEqual     <= 1'b0;
            isLessThan     <= 1'b0;
            isLessThanU    <= 1'b0;
        end else begin
            state          <= state_nxt;
            data_resultRDY <= 1'b0;
            case (state)
                IDLE: begin
                    if (ctrl_start) begin
                        op_a    <= data_operandA;
                        op_b    <= data_operandB;
                        decided <= 1'b0;
                        ltu_r   <= 1'b0;
                        idx     <= IDX_W'(N_CHUNKS - 1);
                    end
                end
                RUN: begin
                    // Only the most significant differing chunk decides ordering.
                    if (!decided && !c_eq) begin
                        decided <= 1'b1;
                        ltu_r   <= c_ltu;
                    end
                    idx <= idx - 1'b1;
                end
                DONE: begin
                    data_resultRDY <= 1'b1;
                    isEqual        <= ~decided;
                    isNotEqual     <= decided;
                    isLessThanU    <= ltu_r;
                    // Differing sign bits: the negative operand is the smaller one.
                    isLessThan     <= decided & (sign_diff ? op_a[WIDTH-1] : ltu_r);
                end
                default: ;
            endcase
        end
    end

endmodule
